game_cmd_ctrl: RTL and testbench

GAME_CMD_CTRL -- requirements
Module: game_cmd_ctrl

---
 rtl/game_cmd_if.sv | 21 ++
 rtl/game_cmd_ctrl.sv | 111 +++++++++++
 tb/tb_game_cmd_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/game_cmd_if.sv
// Button/state/command bundle between the game FSM side and the command controller.
// slave is the controller's view; master is the driver of buttons and game state.
interface game_cmd_if;
   logic       btnStart_n;
   logic       btnPause_n;
   logic       btnReset_n;
   logic [2:0] stateGame;
   logic       startGame;
   logic       pauseGame;
   logic       reset;

   modport master (
      output btnStart_n, btnPause_n, btnReset_n, stateGame,
      input  startGame, pauseGame, reset
   );

   modport slave (
      input  btnStart_n, btnPause_n, btnReset_n, stateGame,
      output startGame, pauseGame, reset
   );
endinterface

// File: rtl/game_cmd_ctrl.sv
// Push-button command controller: per-button sync + debounce, then a registered
// command stage turning press events into start/reset pulses and a pause level.

module game_cmd_db #(
   parameter int DB_CYCLES = 250000,
   parameter int DB_WIDTH  = 18
) (
   input  logic clk,
   input  logic resetFSM,
   input  logic btn_n,
   output logic press
);
   localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

   logic [1:0]          sync;
   logic                db;
   logic [DB_WIDTH-1:0] cnt;

   // sync[1] is the only copy of the button seen by the debounce logic
   always_ff @(posedge clk or posedge resetFSM) begin
      if (resetFSM) begin
         sync  <= 2'b11;
         db    <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_n};
         press <= 1'b0;
         if (sync[1] == db) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            db    <= sync[1];
            cnt   <= '0;
            press <= ~sync[1];
         end else begin
            cnt <= cnt + DB_WIDTH'(1);
         end
      end
   end
endmodule

module game_cmd_ctrl #(
   parameter int DB_CYCLES = 250000,
   parameter int DB_WIDTH  = 18
) (
   input logic       clk,
   input logic       resetFSM,
   game_cmd_if.slave bus
);
   localparam logic [2:0] ST_PLAYING = 3'b001;
   localparam logic [2:0] ST_PAUSE   = 3'b010;

   localparam int EV_START = 0;
   localparam int EV_PAUSE = 1;
   localparam int EV_RST   = 2;

   logic [2:0] btn_n;
   logic [2:0] ev;
   logic       start_q, pause_q, reset_q;

   assign btn_n = {bus.btnReset_n, bus.btnPause_n, bus.btnStart_n};

   game_cmd_db #(
      .DB_CYCLES(DB_CYCLES),
      .DB_WIDTH (DB_WIDTH)
   ) u_db [2:0] (
      .clk     (clk),
      .resetFSM(resetFSM),
      .btn_n   (btn_n),
      .press   (ev)
   );

   // Reset wins over everything; in PLAYING a pause press outranks start.
   always_ff @(posedge clk or posedge resetFSM) begin
      if (resetFSM) begin
         start_q <= 1'b0;
         pause_q <= 1'b0;
         reset_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         reset_q <= 1'b0;
         if (ev[EV_RST]) begin
            reset_q <= 1'b1;
            pause_q <= 1'b0;
         end else begin
            case (bus.stateGame)
               ST_PLAYING: begin
                  if (ev[EV_PAUSE])      pause_q <= 1'b1;
                  else if (ev[EV_START]) start_q <= 1'b1;
               end
               ST_PAUSE: begin
                  if (ev[EV_START]) begin
                     start_q <= 1'b1;
                     pause_q <= 1'b0;
                  end else if (ev[EV_PAUSE]) begin
                     pause_q <= 1'b0;
                  end
               end
               default: begin
                  pause_q <= 1'b0;
                  start_q <= ev[EV_START];
               end
            endcase
         end
      end
   end

   assign bus.startGame = start_q;
   assign bus.pauseGame = pause_q;
   assign bus.reset     = reset_q;
endmodule

// File: tb/tb_game_cmd_ctrl.sv
// Directed bench for game_cmd_ctrl with DB_CYCLES=4: table of press vectors plus
// hand-written reset, glitch and state-driven pause-clear sequences.
module tb_game_cmd_ctrl;
   localparam int DBC = 4;
   localparam logic [2:0] S_START = 3'd0, S_PLAY = 3'd1, S_PAUSE = 3'd2,
                          S_RESET = 3'd3, S_OVER = 3'd4;
   localparam logic [2:0] M_S = 3'b001, M_P = 3'b010, M_R = 3'b100;

   typedef struct {
      logic [2:0] st;
      logic [2:0] mask;
      logic       e_start;
      logic       e_pause;
      logic       e_reset;
   } vec_t;

   logic clk = 1'b0;
   logic resetFSM;
   game_cmd_if bus();

   game_cmd_ctrl #(.DB_CYCLES(DBC), .DB_WIDTH(3)) dut (
      .clk(clk), .resetFSM(resetFSM), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int start_cnt = 0, reset_cnt = 0, phigh = 0;
   vec_t tbl[16];
   logic exp_pause;

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkn(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.startGame === 1'b1) start_cnt++;
      if (bus.reset === 1'b1) reset_cnt++;
      if (bus.pauseGame === 1'b1) phigh++;
      check1("start_reset_exclusive", bus.startGame & bus.reset, 1'b0);
   endtask

   task automatic set_btns(input logic [2:0] mask);
      bus.btnStart_n = ~mask[0];
      bus.btnPause_n = ~mask[1];
      bus.btnReset_n = ~mask[2];
   endtask

   // full press: hold 7 edges (event lands on edge 7), release and let it settle
   task automatic press(input logic [2:0] mask);
      set_btns(mask);
      repeat (7) tick();
      set_btns(3'b000);
      repeat (10) tick();
   endtask

   initial begin
      tbl[0]  = '{S_PLAY,  M_P,           1'b0, 1'b1, 1'b0};
      tbl[1]  = '{S_PAUSE, M_P,           1'b0, 1'b0, 1'b0};
      tbl[2]  = '{S_PAUSE, M_S,           1'b1, 1'b0, 1'b0};
      tbl[3]  = '{S_PLAY,  M_P,           1'b0, 1'b1, 1'b0};
      tbl[4]  = '{S_PAUSE, M_S,           1'b1, 1'b0, 1'b0};
      tbl[5]  = '{S_PLAY,  M_P,           1'b0, 1'b1, 1'b0};
      tbl[6]  = '{S_PAUSE, M_S | M_P,     1'b1, 1'b0, 1'b0};
      tbl[7]  = '{S_PLAY,  M_S | M_P,     1'b0, 1'b1, 1'b0};
      tbl[8]  = '{S_PLAY,  M_S,           1'b1, 1'b1, 1'b0};
      tbl[9]  = '{S_PLAY,  M_R | M_S,     1'b0, 1'b0, 1'b1};
      tbl[10] = '{S_START, M_S,           1'b1, 1'b0, 1'b0};
      tbl[11] = '{S_OVER,  M_P,           1'b0, 1'b0, 1'b0};
      tbl[12] = '{S_START, M_S | M_P,     1'b1, 1'b0, 1'b0};
      tbl[13] = '{S_PLAY,  M_P,           1'b0, 1'b1, 1'b0};
      tbl[14] = '{S_PLAY,  M_R,           1'b0, 1'b0, 1'b1};
      tbl[15] = '{S_PLAY,  M_R | M_S | M_P, 1'b0, 1'b0, 1'b1};

      // reset with all buttons released
      resetFSM = 1'b1;
      set_btns(3'b000);
      bus.stateGame = S_START;
      repeat (3) tick();
      check1("rst_start", bus.startGame, 1'b0);
      check1("rst_pause", bus.pauseGame, 1'b0);
      check1("rst_reset", bus.reset, 1'b0);
      resetFSM = 1'b0;
      start_cnt = 0; reset_cnt = 0; phigh = 0;
      repeat (10) tick();
      checkn("post_rst_start_pulses", start_cnt, 0);
      checkn("post_rst_reset_pulses", reset_cnt, 0);
      checkn("post_rst_pause_cycles", phigh, 0);

      exp_pause = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.stateGame = tbl[i].st;
         start_cnt = 0; reset_cnt = 0;
         set_btns(tbl[i].mask);
         repeat (6) tick();
         check1($sformatf("v%0d pause_edge6", i), bus.pauseGame, exp_pause);
         tick();
         check1($sformatf("v%0d start_edge7", i), bus.startGame, tbl[i].e_start);
         check1($sformatf("v%0d pause_edge7", i), bus.pauseGame, tbl[i].e_pause);
         check1($sformatf("v%0d reset_edge7", i), bus.reset, tbl[i].e_reset);
         tick();
         check1($sformatf("v%0d pause_edge8", i), bus.pauseGame, tbl[i].e_pause);
         set_btns(3'b000);
         repeat (10) tick();
         checkn($sformatf("v%0d start_pulses", i), start_cnt, int'(tbl[i].e_start));
         checkn($sformatf("v%0d reset_pulses", i), reset_cnt, int'(tbl[i].e_reset));
         exp_pause = tbl[i].e_pause;
      end

      // resetFSM mid-debounce, button kept held: re-debounce from zero, one pulse
      bus.stateGame = S_START;
      start_cnt = 0;
      set_btns(M_S);
      repeat (4) tick();
      resetFSM = 1'b1;
      repeat (2) tick();
      checkn("midrst_no_pulse", start_cnt, 0);
      resetFSM = 1'b0;
      repeat (6) tick();
      check1("held_edge6", bus.startGame, 1'b0);
      tick();
      check1("held_edge7", bus.startGame, 1'b1);
      repeat (13) tick();
      checkn("held_single_pulse", start_cnt, 1);
      set_btns(3'b000);
      repeat (10) tick();

      // short pause glitches never reach the command stage
      bus.stateGame = S_PLAY;
      phigh = 0;
      for (int k = 0; k < 5; k++) begin
         set_btns(M_P);
         repeat (3) tick();
         set_btns(3'b000);
         repeat (3) tick();
      end
      repeat (10) tick();
      checkn("glitch_pause_cycles", phigh, 0);

      // pause level cleared by game state alone
      press(M_P);
      check1("pause_set_before_over", bus.pauseGame, 1'b1);
      bus.stateGame = S_OVER;
      tick();
      check1("pause_clr_gameover", bus.pauseGame, 1'b0);
      bus.stateGame = S_PLAY;
      press(M_P);
      check1("pause_set_before_undef", bus.pauseGame, 1'b1);
      bus.stateGame = 3'b110;
      tick();
      check1("pause_clr_undef", bus.pauseGame, 1'b0);
      bus.stateGame = S_PLAY;
      press(M_P);
      bus.stateGame = S_RESET;
      tick();
      check1("pause_clr_reset_state", bus.pauseGame, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
